// File: rtl/spike_event_queue.sv
// -----------------------------------------------------------------------------
// spike_event_queue
//
// Sits after the adder/comparator stage of a single neuron. It qualifies the
// comparator spike and blocks the neuron for a refractory period after each
// accepted spike. Each accepted spike requests a membrane-potential clear and
// is timestamped and queued in a small FIFO. The RISC-V core drains the queue.
//
// Optional feature macro: SEQ_POTENTIAL_EN
//   defined   : queue entry = {neuron_id, ts, potential_in}
//   undefined : queue entry = {neuron_id, ts}; potential_in is unused
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-low reset
//   sample_valid   spike_in/potential_in valid this cycle
//   spike_in       comparator output
//   potential_in   adder output at the spike
//   neuron_id      static id stamped into events
//   timestep_tick  one-cycle pulse; advances timestamp and refractory count
//   rd_en          core pops the head entry
//   clr_overflow   clears the sticky overflow flag
//   rd_data        head entry (first-word-fall-through); 0 when empty
//   rd_valid       queue non-empty
//   fifo_count     occupancy
//   fifo_full      occupancy == FIFO_DEPTH
//   overflow       sticky: an accepted event was dropped
//   membrane_clr   one-cycle pulse the cycle after an accepted spike
//   refractory     high while the neuron is blocked
// -----------------------------------------------------------------------------
module spike_event_queue #(
   parameter int DATA_WIDTH    = 16,
   parameter int NID_WIDTH     = 4,
   parameter int TS_WIDTH      = 16,
   parameter int FIFO_DEPTH    = 8,
   parameter int REFRACT_TICKS = 4,
`ifdef SEQ_POTENTIAL_EN
   localparam int ENTRY_W      = NID_WIDTH + TS_WIDTH + DATA_WIDTH,
`else
   localparam int ENTRY_W      = NID_WIDTH + TS_WIDTH,
`endif
   localparam int CNT_W        = $clog2(FIFO_DEPTH) + 1
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  sample_valid,
   input  logic                  spike_in,
   input  logic [DATA_WIDTH-1:0] potential_in,
   input  logic [NID_WIDTH-1:0]  neuron_id,
   input  logic                  timestep_tick,
   input  logic                  rd_en,
   input  logic                  clr_overflow,
   output logic [ENTRY_W-1:0]    rd_data,
   output logic                  rd_valid,
   output logic [CNT_W-1:0]      fifo_count,
   output logic                  fifo_full,
   output logic                  overflow,
   output logic                  membrane_clr,
   output logic                  refractory
);

   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int RCNT_W = (REFRACT_TICKS > 0) ? $clog2(REFRACT_TICKS + 1) : 1;

   localparam logic [0:0] ST_READY   = 1'b0;
   localparam logic [0:0] ST_REFRACT = 1'b1;

   logic [0:0]          r_state;
   logic [RCNT_W-1:0]   r_rcnt;
   logic [TS_WIDTH-1:0] r_ts;
   logic                r_membrane_clr;
   logic                r_overflow;
   logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    r_wr_ptr;
   logic [PTR_W-1:0]    r_rd_ptr;
   logic [CNT_W-1:0]    r_count;

   logic                w_accept;
   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_push;
   logic                w_drop;
   logic [ENTRY_W-1:0]  w_entry;

`ifdef SEQ_POTENTIAL_EN
   assign w_entry = {neuron_id, r_ts, potential_in};
`else
   assign w_entry = {neuron_id, r_ts};
   logic w_unused_potential;
   assign w_unused_potential = ^potential_in;
`endif

   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == CNT_W'(FIFO_DEPTH));
   assign w_accept = (r_state == ST_READY) && sample_valid && spike_in;
   // A pop only happens on a non-empty queue, so push+pop on an empty queue
   // degenerates to a plain push.
   assign w_pop    = rd_en && !w_empty;
   // When full, a same-cycle pop frees the slot the push needs.
   assign w_push   = w_accept && (!w_full || w_pop);
   assign w_drop   = w_accept && w_full && !w_pop;

   // Timestamp: events capture the value before this cycle's increment.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ts <= '0;
      end else if (timestep_tick) begin
         r_ts <= r_ts + TS_WIDTH'(1);
      end
   end

   // Refractory FSM. The tick on the accept cycle is seen in READY and so
   // does not count toward the refractory period.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state        <= ST_READY;
         r_rcnt         <= '0;
         r_membrane_clr <= 1'b0;
      end else begin
         r_membrane_clr <= w_accept;
         if (r_state == ST_READY) begin
            if (w_accept && (REFRACT_TICKS > 0)) begin
               r_state <= ST_REFRACT;
               r_rcnt  <= RCNT_W'(REFRACT_TICKS);
            end
         end else begin
            if (timestep_tick) begin
               r_rcnt <= r_rcnt - RCNT_W'(1);
               if (r_rcnt == RCNT_W'(1)) begin
                  r_state <= ST_READY;
               end
            end
         end
      end
   end

   // FIFO control: pointers wrap naturally since FIFO_DEPTH is a power of 2.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
         end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
         end
         // Setting wins over a same-cycle clear so no drop goes unreported.
         if (w_drop) begin
            r_overflow <= 1'b1;
         end else if (clr_overflow) begin
            r_overflow <= 1'b0;
         end
      end
   end

   // NOTE: storage is deliberately not reset; the count/pointers define which
   // entries are live, and rd_data is masked to 0 while empty.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= w_entry;
      end
   end

   assign rd_data      = w_empty ? '0 : r_mem[r_rd_ptr];
   assign rd_valid     = !w_empty;
   assign fifo_count   = r_count;
   assign fifo_full    = w_full;
   assign overflow     = r_overflow;
   assign membrane_clr = r_membrane_clr;
   assign refractory   = (r_state == ST_REFRACT);

endmodule

// File: tb/tb_spike_event_queue.sv
// -----------------------------------------------------------------------------
// tb_spike_event_queue
//
// Two instances share one stimulus bus:
//   dut_a : defaults (TS_WIDTH=16, REFRACT_TICKS=4)   -> refractory behaviour
//   dut_b : TS_WIDTH=4, REFRACT_TICKS=0               -> overflow, full, wrap
// Inputs change 1 time unit after the rising edge; outputs are sampled there
// too, so each check sees the effect of the inputs applied on the prior edge.
// -----------------------------------------------------------------------------
module tb_spike_event_queue;

`ifdef SEQ_POTENTIAL_EN
   localparam int EW_A = 4 + 16 + 16;
   localparam int EW_B = 4 + 4 + 16;
`else
   localparam int EW_A = 4 + 16;
   localparam int EW_B = 4 + 4;
`endif

   logic            clk = 1'b0;
   logic            reset = 1'b0;
   logic            sample_valid = 1'b0;
   logic            spike_in = 1'b0;
   logic [15:0]     potential_in = 16'd1000;
   logic [3:0]      neuron_id = 4'd3;
   logic            timestep_tick = 1'b0;
   logic            rd_en = 1'b0;
   logic            clr_overflow = 1'b0;

   logic [EW_A-1:0] rd_data_a;
   logic            rd_valid_a, fifo_full_a, overflow_a, membrane_clr_a, refractory_a;
   logic [3:0]      fifo_count_a;
   logic [EW_B-1:0] rd_data_b;
   logic            rd_valid_b, fifo_full_b, overflow_b, membrane_clr_b, refractory_b;
   logic [3:0]      fifo_count_b;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   spike_event_queue dut_a (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .spike_in(spike_in),
      .potential_in(potential_in), .neuron_id(neuron_id), .timestep_tick(timestep_tick),
      .rd_en(rd_en), .clr_overflow(clr_overflow), .rd_data(rd_data_a),
      .rd_valid(rd_valid_a), .fifo_count(fifo_count_a), .fifo_full(fifo_full_a),
      .overflow(overflow_a), .membrane_clr(membrane_clr_a), .refractory(refractory_a)
   );

   spike_event_queue #(.TS_WIDTH(4), .REFRACT_TICKS(0)) dut_b (
      .clk(clk), .reset(reset), .sample_valid(sample_valid), .spike_in(spike_in),
      .potential_in(potential_in), .neuron_id(neuron_id), .timestep_tick(timestep_tick),
      .rd_en(rd_en), .clr_overflow(clr_overflow), .rd_data(rd_data_b),
      .rd_valid(rd_valid_b), .fifo_count(fifo_count_b), .fifo_full(fifo_full_b),
      .overflow(overflow_b), .membrane_clr(membrane_clr_b), .refractory(refractory_b)
   );

   typedef struct {
      logic sv;
      logic sp;
      logic tk;
      logic rd;
      int   cnt;
      logic clr;
      logic refr;
      int   ts;
   } vec_t;

   vec_t vecs [22];

   function automatic logic [EW_A-1:0] ent_a(input int ts);
`ifdef SEQ_POTENTIAL_EN
      return {4'd3, 16'(ts), 16'd1000};
`else
      return {4'd3, 16'(ts)};
`endif
   endfunction

   function automatic logic [EW_B-1:0] ent_b(input int ts);
`ifdef SEQ_POTENTIAL_EN
      return {4'd3, 4'(ts), 16'd1000};
`else
      return {4'd3, 4'(ts)};
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step(input logic sv, input logic sp, input logic tk,
                       input logic rd, input logic co);
      sample_valid  = sv;
      spike_in      = sp;
      timestep_tick = tk;
      rd_en         = rd;
      clr_overflow  = co;
      @(posedge clk);
      #1;
   endtask

   task automatic check_a(input string tag, input int cnt, input logic clr,
                          input logic refr, input logic ovf, input int ts);
      logic [EW_A-1:0] exp_data;
      exp_data = (cnt == 0) ? '0 : ent_a(ts);
      check({tag, ".a.count"},    64'(fifo_count_a),   64'(cnt));
      check({tag, ".a.valid"},    64'(rd_valid_a),     64'(cnt != 0));
      check({tag, ".a.full"},     64'(fifo_full_a),    64'(cnt == 8));
      check({tag, ".a.clr"},      64'(membrane_clr_a), 64'(clr));
      check({tag, ".a.refr"},     64'(refractory_a),   64'(refr));
      check({tag, ".a.ovf"},      64'(overflow_a),     64'(ovf));
      check({tag, ".a.data"},     64'(rd_data_a),      64'(exp_data));
   endtask

   task automatic check_b(input string tag, input int cnt, input logic clr,
                          input logic ovf, input int ts);
      logic [EW_B-1:0] exp_data;
      exp_data = (cnt == 0) ? '0 : ent_b(ts);
      check({tag, ".b.count"},    64'(fifo_count_b),   64'(cnt));
      check({tag, ".b.valid"},    64'(rd_valid_b),     64'(cnt != 0));
      check({tag, ".b.full"},     64'(fifo_full_b),    64'(cnt == 8));
      check({tag, ".b.clr"},      64'(membrane_clr_b), 64'(clr));
      check({tag, ".b.refr"},     64'(refractory_b),   64'(1'b0));
      check({tag, ".b.ovf"},      64'(overflow_b),     64'(ovf));
      check({tag, ".b.data"},     64'(rd_data_b),      64'(exp_data));
   endtask

   initial begin : main
      int heads [8];
      int exp_cnt;

      // Refractory sequence for dut_a (REFRACT_TICKS=4).
      //            sv    sp    tk    rd   cnt  clr   refr  head_ts
      vecs[0]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};   // ts -> 1
      vecs[1]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
      vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
      vecs[3]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};
      vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};   // ts -> 5
      vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b1, 1'b1, 5};   // accept @ts5
      vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 5};   // ignored
      vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 5};   // rcnt 3
      vecs[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1, 1'b0, 1'b1, 5};   // rcnt 2, spike ignored
      vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b1, 5};   // rcnt 1
      vecs[10] = '{1'b1, 1'b1, 1'b0, 1'b0, 1, 1'b0, 1'b1, 5};   // ignored
      vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1'b0, 1'b0, 5};   // 4th tick -> READY, ts 9
      vecs[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 2, 1'b1, 1'b1, 5};   // accept @ts9 (=5+4), tick ignored by rcnt
      vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1'b0, 1'b1, 9};   // pop
      vecs[14] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 0};   // pop -> empty
      vecs[15] = '{1'b0, 1'b0, 1'b0, 1'b1, 0, 1'b0, 1'b1, 0};   // pop while empty
      vecs[16] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 0};   // rcnt 3
      vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 0};   // rcnt 2
      vecs[18] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 0};   // rcnt 1
      vecs[19] = '{1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 0};   // READY, ts 14
      vecs[20] = '{1'b0, 1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0};   // spike without sample_valid
      vecs[21] = '{1'b1, 1'b1, 1'b0, 1'b1, 1, 1'b1, 1'b1, 14};  // push + rd_en while empty

      // Reset held 2 clocks with spikes and ticks asserted.
      reset = 1'b0;
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      check_a("reset", 0, 1'b0, 1'b0, 1'b0, 0);
      check_b("reset", 0, 1'b0, 1'b0, 0);
      sample_valid  = 1'b0;
      spike_in      = 1'b0;
      timestep_tick = 1'b0;
      reset         = 1'b1;

      for (int i = 0; i < 22; i++) begin
         step(vecs[i].sv, vecs[i].sp, vecs[i].tk, vecs[i].rd, 1'b0);
         check_a($sformatf("vec%0d", i), vecs[i].cnt, vecs[i].clr, vecs[i].refr, 1'b0, vecs[i].ts);
      end

      // Mid-operation reset discards the queued event in dut_a.
      reset = 1'b0;
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      check_a("midreset", 0, 1'b0, 1'b0, 1'b0, 0);
      check_b("midreset", 0, 1'b0, 1'b0, 0);
      reset = 1'b1;

      // dut_b: 9 spikes, each with a tick, no pops -> 8 stored, 1 dropped.
      for (int k = 0; k < 9; k++) begin
         step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         exp_cnt = (k < 8) ? k + 1 : 8;
         check_b($sformatf("fill%0d", k), exp_cnt, 1'b1, (k == 8), 0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_b("clr_ovf", 8, 1'b0, 1'b0, 0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
      check_b("set_beats_clr", 8, 1'b1, 1'b1, 0);
      step(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
      check_b("full_push_pop", 8, 1'b1, 1'b1, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      check_b("clr_ovf2", 8, 1'b0, 1'b0, 1);

      // Drain: timestamp order preserved, ts 8 was dropped, ts 9 was pushed.
      heads = '{1, 2, 3, 4, 5, 6, 7, 9};
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
         check_b($sformatf("drain%0d", i), 7 - i, 1'b0, 1'b0, (i < 7) ? heads[i + 1] : 0);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      check_b("pop_empty", 0, 1'b0, 1'b0, 0);

      // ts has seen 9 ticks; 7 more wrap the 4-bit counter to 0.
      for (int i = 0; i < 7; i++) begin
         step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      end
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      check_b("ts_wrap", 1, 1'b1, 1'b0, 0);
`ifdef SEQ_POTENTIAL_EN
      check("ts_wrap.b.potential", 64'(rd_data_b[15:0]), 64'(16'd1000));
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
